// File: rtl/cflog_pkg.sv
// rtl/cflog_pkg.sv - shared FSM encoding and frame constants for the CFLog drain
// CFLOG_DRAIN_CRC_EN adds the trailing CRC state to the encoding.
package cflog_pkg;

    localparam int          WORD_W       = 16;
    localparam logic [15:0] LOG_SIZE_DEF = 16'h0400;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;

    // Frame = header word carrying the drained count, then the data words.
`ifdef CFLOG_DRAIN_CRC_EN
    localparam bit CRC_EN = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_HDR, S_RD, S_CAP, S_SEND, S_CRC, S_FIN
    } state_t;
`else
    localparam bit CRC_EN = 1'b0;
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_HDR, S_RD, S_CAP, S_SEND, S_FIN
    } state_t;
`endif

endpackage

// File: rtl/cflog_crc16.sv
// rtl/cflog_crc16.sv - combinational next-CRC over one 16-bit word
// CRC-16-CCITT, MSB first; instantiated by cflog_drain only under CFLOG_DRAIN_CRC_EN.
module cflog_crc16
    import cflog_pkg::*;
(
    input  logic [WORD_W-1:0] i_crc,
    input  logic [WORD_W-1:0] i_data,
    output logic [WORD_W-1:0] o_crc
);

    always_comb begin
        o_crc = i_crc;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (o_crc[WORD_W-1] ^ i_data[i]) begin
                o_crc = {o_crc[WORD_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                o_crc = {o_crc[WORD_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/cflog_drain.sv
// rtl/cflog_drain.sv - walks the CFLog RAM and streams it out as a framed word stream
// Optional CFLOG_DRAIN_CRC_EN appends a CRC-16-CCITT word after the data.
module cflog_drain
    import cflog_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] LOG_SIZE = ADDR_W'(LOG_SIZE_DEF)
) (
    input  logic              clk,
    input  logic              puc,
    input  logic              drain_req,
    input  logic [ADDR_W-1:0] log_ptr,
    input  logic              log_hw_wen,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              tx_valid,
    output logic [15:0]       tx_data,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              busy,
    output logic              overflow,
    output logic              log_clear,
    output logic              done
);

    state_t            r_state, w_state_nxt, w_end_state;
    logic              r_pending, w_pending_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx_nxt;
    logic [ADDR_W:0]   w_idx_inc;
    logic              r_ovf, w_ovf_nxt;
    logic [15:0]       r_tx_data, w_data_nxt;
    logic              r_tx_valid, r_tx_last, r_rd_en, r_busy, r_log_clear, r_done;
    logic [ADDR_W-1:0] r_rd_addr, w_addr_nxt;
    logic              w_valid_nxt, w_last_nxt, w_busy_nxt, w_accept;

`ifdef CFLOG_DRAIN_CRC_EN
    logic [15:0] r_crc, w_crc_nxt, w_crc_upd;

    cflog_crc16 u_crc (
        .i_crc  (r_crc),
        .i_data (r_tx_data),
        .o_crc  (w_crc_upd)
    );

    assign w_end_state = S_CRC;

    always_comb begin
        w_crc_nxt = r_crc;
        if (r_state == S_ARM) begin
            w_crc_nxt = CRC_INIT;
        end else if ((r_state == S_HDR || r_state == S_SEND) && w_accept) begin
            w_crc_nxt = w_crc_upd;
        end
    end

    always_ff @(posedge clk) begin
        if (puc) r_crc <= '0;
        else     r_crc <= w_crc_nxt;
    end
`else
    assign w_end_state = S_FIN;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_ovf_nxt     = r_ovf;
        w_data_nxt    = r_tx_data;
        w_accept      = r_tx_valid && tx_ready;
        w_idx_inc     = {1'b0, r_idx} + 1'b1;

        case (r_state)
            S_IDLE: begin
                if (drain_req) w_pending_nxt = 1'b1;
                // Hold off while the writer is mid-store so its last entry lands in the frame.
                if (r_pending && !log_hw_wen) w_state_nxt = S_ARM;
            end
            S_ARM: begin
                w_cnt_nxt   = (log_ptr > LOG_SIZE) ? LOG_SIZE : log_ptr;
                w_ovf_nxt   = (log_ptr > LOG_SIZE);
                w_idx_nxt   = '0;
                w_data_nxt  = 16'(w_cnt_nxt);
                w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_accept) w_state_nxt = (r_cnt != '0) ? S_RD : w_end_state;
            end
            S_RD: w_state_nxt = S_CAP;
            S_CAP: begin
                w_data_nxt  = rd_data;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_accept) begin
                    w_idx_nxt   = w_idx_inc[ADDR_W-1:0];
                    w_state_nxt = (w_idx_inc < {1'b0, r_cnt}) ? S_RD : w_end_state;
                end
            end
`ifdef CFLOG_DRAIN_CRC_EN
            S_CRC: begin
                if (w_accept) w_state_nxt = S_FIN;
            end
`endif
            S_FIN: begin
                w_pending_nxt = 1'b0;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef CFLOG_DRAIN_CRC_EN
        if (w_state_nxt == S_CRC && r_state != S_CRC) w_data_nxt = w_crc_upd;
`endif
        if (w_state_nxt == S_FIN) w_ovf_nxt = 1'b0;

        // Outputs are registered, so they are decoded from the next state.
        w_valid_nxt = (w_state_nxt == S_HDR) || (w_state_nxt == S_SEND);
        w_last_nxt  = 1'b0;
        if (w_state_nxt == S_HDR) begin
            w_last_nxt = !CRC_EN && (w_cnt_nxt == '0);
        end else if (w_state_nxt == S_SEND) begin
            w_last_nxt = !CRC_EN && (({1'b0, w_idx_nxt} + 1'b1) == {1'b0, w_cnt_nxt});
        end
`ifdef CFLOG_DRAIN_CRC_EN
        if (w_state_nxt == S_CRC) begin
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b1;
        end
`endif
        w_busy_nxt = !(w_state_nxt == S_IDLE || w_state_nxt == S_ARM || w_state_nxt == S_FIN);
        w_addr_nxt = (w_state_nxt == S_RD) ? w_idx_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (puc) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_ovf       <= 1'b0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_log_clear <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_ovf       <= w_ovf_nxt;
            r_tx_data   <= w_data_nxt;
            r_tx_valid  <= w_valid_nxt;
            r_tx_last   <= w_last_nxt;
            r_rd_en     <= (w_state_nxt == S_RD);
            r_rd_addr   <= w_addr_nxt;
            r_busy      <= w_busy_nxt;
            r_log_clear <= (w_state_nxt == S_FIN);
            r_done      <= (w_state_nxt == S_FIN);
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign tx_last   = r_tx_last;
    assign busy      = r_busy;
    assign overflow  = r_ovf;
    assign log_clear = r_log_clear;
    assign done      = r_done;

endmodule

// File: tb/tb_cflog_drain.sv
// tb/tb_cflog_drain.sv - self-checking bench for cflog_drain against a frame-level model
// Honours CFLOG_DRAIN_CRC_EN when building expected frames.
module tb_cflog_drain;

    localparam int LSZ = 1024;

    logic        clk = 1'b0;
    logic        puc = 1'b1;
    logic        drain_req = 1'b0;
    logic [15:0] log_ptr = '0;
    logic        log_hw_wen = 1'b0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_last;
    logic        tx_ready = 1'b1;
    logic        busy, overflow, log_clear, done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] mem [0:2047];
    logic [15:0] exp_q[$];
    logic [15:0] cap_d[$];
    bit          cap_l[$];
    int          n_clear = 0, n_done = 0, n_rd = 0, stab_err = 0, ovf_low = 0, ovf_high = 0;
    logic [15:0] last_addr = '0;
    int          rdy_mode = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

    cflog_drain #(.ADDR_W(16), .LOG_SIZE(16'h0400)) dut (
        .clk(clk), .puc(puc), .drain_req(drain_req), .log_ptr(log_ptr),
        .log_hw_wen(log_hw_wen), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .busy(busy), .overflow(overflow), .log_clear(log_clear), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[10:0]];

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (puc) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data || tx_last !== prev_last)) stab_err++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
            if (tx_valid && tx_ready) begin
                cap_d.push_back(tx_data);
                cap_l.push_back(tx_last);
            end
            if (log_clear) n_clear++;
            if (done) n_done++;
            if (rd_en) begin
                n_rd++;
                last_addr = rd_addr;
            end
            if (busy && overflow) ovf_high++;
            if (busy && !overflow) ovf_low++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_step(logic [15:0] c, logic [15:0] d);
        logic fb;
        for (int b = 15; b >= 0; b--) begin
            fb = c[15] ^ d[b];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic fill_mem(input int n);
        for (int i = 0; i < n; i++) mem[i] = 16'($urandom);
    endtask

    task automatic build_exp(input int ptr);
        int          cnt;
        logic [15:0] crc;
        cnt = (ptr > LSZ) ? LSZ : ptr;
        exp_q.delete();
        exp_q.push_back(16'(cnt));
        for (int i = 0; i < cnt; i++) exp_q.push_back(mem[i]);
`ifdef CFLOG_DRAIN_CRC_EN
        crc = 16'hFFFF;
        foreach (exp_q[i]) crc = crc_step(crc, exp_q[i]);
        exp_q.push_back(crc);
`endif
        crc = '0;
    endtask

    function automatic int frame_err(input int base);
        if (cap_d.size() - base != exp_q.size()) return -2;
        foreach (exp_q[i]) begin
            if (cap_d[base+i] !== exp_q[i] || cap_l[base+i] != (i == exp_q.size() - 1)) return i;
        end
        return -1;
    endfunction

    task automatic wait_done(input int d0, output bit ok);
        ok = 0;
        for (int c = 0; c < 8000 && !ok; c++) begin
            tick();
            if (n_done > d0) ok = 1;
        end
    endtask

    task automatic run_frame(input int ptr, input int mode, output int base, output bit ok);
        int d0;
        rdy_mode = mode;
        log_ptr  = 16'(ptr);
        build_exp(ptr);
        base = cap_d.size();
        d0   = n_done;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        wait_done(d0, ok);
        tick();
    endtask

    task automatic test_reset();
        int nb;
        puc = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({tx_valid, tx_last, rd_en, busy, overflow, log_clear, done} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 0000000", {tx_valid, tx_last, rd_en, busy, overflow, log_clear, done});
        end
        tests_run++;
        if (tx_data !== 16'h0 || rd_addr !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_data got data=%h addr=%h want 0000 0000", tx_data, rd_addr);
        end
        puc = 1'b0;
        nb = 0;
        repeat (6) begin
            tick();
            if (busy) nb++;
        end
        tests_run++;
        if (nb !== 0) begin
            tests_failed++;
            $display("FAIL idle_no_req got busy_cycles=%0d want 0", nb);
        end
    endtask

    task automatic test_basic();
        int base, e, rc, rr, oh;
        bit ok;
        mem[0] = 16'hA001; mem[1] = 16'hA002; mem[2] = 16'hA003;
        rc = n_clear; rr = n_rd; oh = ovf_high;
        run_frame(3, 0, base, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL basic_timeout got no done want done"); end
        e = frame_err(base);
        tests_run++;
        if (e !== -1) begin tests_failed++; $display("FAIL basic_frame got err_at=%0d want -1", e); end
        tests_run++;
        if (n_clear - rc !== 1) begin tests_failed++; $display("FAIL basic_clear got %0d want 1", n_clear - rc); end
        tests_run++;
        if (n_rd - rr !== 3) begin tests_failed++; $display("FAIL basic_reads got %0d want 3", n_rd - rr); end
        tests_run++;
        if (ovf_high - oh !== 0) begin tests_failed++; $display("FAIL basic_ovf got %0d want 0", ovf_high - oh); end
    endtask

    task automatic test_empty();
        int base, e, rc, rr;
        bit ok;
        rc = n_clear; rr = n_rd;
        run_frame(0, 0, base, ok);
        e = frame_err(base);
        tests_run++;
        if (!ok || e !== -1) begin tests_failed++; $display("FAIL empty_frame got ok=%0d err_at=%0d want 1 -1", ok, e); end
        tests_run++;
        if (n_rd - rr !== 0) begin tests_failed++; $display("FAIL empty_reads got %0d want 0", n_rd - rr); end
        tests_run++;
        if (n_clear - rc !== 1) begin tests_failed++; $display("FAIL empty_clear got %0d want 1", n_clear - rc); end
    endtask

    task automatic test_overflow();
        int base, e, rr, ol, oh;
        bit ok;
        fill_mem(LSZ);
        rr = n_rd; ol = ovf_low; oh = ovf_high;
        run_frame(16'h0405, 0, base, ok);
        e = frame_err(base);
        tests_run++;
        if (!ok || e !== -1) begin tests_failed++; $display("FAIL ovf_frame got ok=%0d err_at=%0d want 1 -1", ok, e); end
        tests_run++;
        if (n_rd - rr !== LSZ || last_addr !== 16'h03FF) begin
            tests_failed++;
            $display("FAIL ovf_reads got n=%0d last=%h want 1024 03ff", n_rd - rr, last_addr);
        end
        tests_run++;
        if (ovf_low - ol !== 0 || ovf_high - oh == 0) begin
            tests_failed++;
            $display("FAIL ovf_flag got low=%0d high=%0d want 0 >0", ovf_low - ol, ovf_high - oh);
        end
    endtask

    task automatic test_stall();
        int base, e, se;
        bit ok;
        mem[0] = 16'hA001; mem[1] = 16'hA002; mem[2] = 16'hA003;
        se = stab_err;
        run_frame(3, 1, base, ok);
        e = frame_err(base);
        tests_run++;
        if (!ok || e !== -1) begin tests_failed++; $display("FAIL stall_frame got ok=%0d err_at=%0d want 1 -1", ok, e); end
        fill_mem(12);
        run_frame(12, 2, base, ok);
        e = frame_err(base);
        tests_run++;
        if (!ok || e !== -1) begin tests_failed++; $display("FAIL stall_rand_frame got ok=%0d err_at=%0d want 1 -1", ok, e); end
        tests_run++;
        if (stab_err - se !== 0) begin tests_failed++; $display("FAIL stall_stable got %0d want 0", stab_err - se); end
        rdy_mode = 0;
    endtask

    task automatic test_hw_wen();
        int base, e, d0, nb;
        bit ok;
        fill_mem(8);
        rdy_mode = 0;
        base = cap_d.size(); d0 = n_done; nb = 0;
        log_ptr = 16'd4; log_hw_wen = 1'b1; drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        if (busy) nb++;
        tick();
        if (busy) nb++;
        log_ptr = 16'd5; log_hw_wen = 1'b0;
        build_exp(5);
        repeat (4) tick();
        log_ptr = 16'd9; log_hw_wen = 1'b1;
        wait_done(d0, ok);
        log_hw_wen = 1'b0;
        tick();
        tests_run++;
        if (nb !== 0) begin tests_failed++; $display("FAIL wen_hold got busy_cycles=%0d want 0", nb); end
        e = frame_err(base);
        tests_run++;
        if (!ok || e !== -1) begin tests_failed++; $display("FAIL wen_frame got ok=%0d err_at=%0d want 1 -1", ok, e); end
    endtask

    task automatic test_ignore();
        int d0, nb, rr;
        bit ok, hit;
        int base;
        fill_mem(2);
        rdy_mode = 0; log_ptr = 16'd2;
        d0 = n_done;
        drain_req = 1'b1; tick(); drain_req = 1'b0;
        repeat (4) tick();
        drain_req = 1'b1; tick(); drain_req = 1'b0;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            tick();
            if (log_clear) hit = 1;
        end
        drain_req = 1'b1; tick(); drain_req = 1'b0;
        rr = n_rd; nb = 0;
        repeat (20) begin
            tick();
            if (busy) nb++;
        end
        tests_run++;
        if (!hit || n_done - d0 !== 1) begin tests_failed++; $display("FAIL ignore_single got fin=%0d done=%0d want 1 1", hit, n_done - d0); end
        tests_run++;
        if (nb !== 0 || n_rd !== rr) begin tests_failed++; $display("FAIL ignore_requeue got busy=%0d reads=%0d want 0 0", nb, n_rd - rr); end
        ok = 0; base = 0;
    endtask

    task automatic test_abort();
        int base, e, rc, dc, nb;
        bit ok, hit;
        fill_mem(6);
        rdy_mode = 0; log_ptr = 16'd6;
        rc = n_clear; dc = n_done;
        base = cap_d.size();
        drain_req = 1'b1; tick(); drain_req = 1'b0;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            tick();
            if (tx_valid && cap_d.size() - base == 2) hit = 1;
        end
        puc = 1'b1;
        tick();
        tests_run++;
        if (!hit || {tx_valid, tx_last, rd_en, busy, overflow, log_clear, done, tx_data, rd_addr} !== 39'b0) begin
            tests_failed++;
            $display("FAIL abort_outputs got hit=%0d v=%b d=%h busy=%b want 1 0 0000 0", hit, tx_valid, tx_data, busy);
        end
        puc = 1'b0;
        nb = 0;
        repeat (10) begin
            tick();
            if (busy) nb++;
        end
        tests_run++;
        if (n_clear !== rc || n_done !== dc || nb !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_clear got clear=%0d done=%0d busy=%0d want 0 0 0", n_clear - rc, n_done - dc, nb);
        end
        fill_mem(3);
        run_frame(3, 2, base, ok);
        e = frame_err(base);
        tests_run++;
        if (!ok || e !== -1) begin tests_failed++; $display("FAIL abort_restart got ok=%0d err_at=%0d want 1 -1", ok, e); end
        rdy_mode = 0;
    endtask

    task automatic test_random();
        int base, e, ptr, mode;
        bit ok;
        for (int k = 0; k < 6; k++) begin
            ptr  = $urandom_range(0, 24);
            mode = $urandom_range(0, 2);
            fill_mem(ptr);
            run_frame(ptr, mode, base, ok);
            e = frame_err(base);
            tests_run++;
            if (!ok || e !== -1) begin
                tests_failed++;
                $display("FAIL random_frame ptr=%0d mode=%0d got ok=%0d err_at=%0d want 1 -1", ptr, mode, ok, e);
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_stall();
        test_hw_wen();
        test_ignore();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
